mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/struct_pkg.sv | 70 +++++++
 rtl/load_ext.sv | 28 ++
 rtl/mem_stage.sv | 128 ++++++++++++
 tb/tb_mem_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/struct_pkg.sv
// Shared types, FSM states and funct3 encodings for the MEM pipeline stage.
package struct_pkg;

   typedef struct packed {
      logic        valid;
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [31:0] result;
      logic [31:0] s_data;
   } exmem_t;

   typedef struct packed {
      logic        valid;
      logic        regWrite;
      logic [4:0]  rd;
      logic [31:0] wb_data;
   } memwb_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // sz is funct3[1:0]: 00 byte, 01 half, otherwise word.
   function automatic logic [1:0] nat_lane(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'b00:   nat_lane = a;
         2'b01:   nat_lane = {a[1], 1'b0};
         default: nat_lane = 2'b00;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = a[0];
         default: misaligned = (a != 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] lane);
      case (sz)
         2'b00:   store_be = 4'b0001 << lane;
         2'b01:   store_be = 4'b0011 << lane;
         default: store_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] sd);
      case (sz)
         2'b00:   store_wdata = {4{sd[7:0]}};
         2'b01:   store_wdata = {2{sd[15:0]}};
         default: store_wdata = sd;
      endcase
   endfunction

endpackage

// File: rtl/load_ext.sv
// Load lane select and sign/zero extension of the returned memory word.
import struct_pkg::*;

module load_ext (
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [3:0][7:0] bytes;
   logic [7:0]      b;
   logic [15:0]     h;

   always_comb begin
      bytes = rdata;
      b     = bytes[lane];
      h     = lane[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   data = {{24{b[7]}}, b};
         F3_LBU:  data = {24'h0, b};
         F3_LH:   data = {{16{h[15]}}, h};
         F3_LHU:  data = {16'h0, h};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses, extends loads, aborts on timeout.
// Optional MISALIGN_TRAP_EN traps misaligned accesses instead of force-aligning them.
import struct_pkg::*;

module mem_stage #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  exmem_t      ex_in,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output memwb_t      wb_out,
   output logic        bus_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   mem_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic             op_store;
   logic             op_rw;
   logic [4:0]       op_rd;
   logic [2:0]       op_f3;
   logic [1:0]       op_lane;
   logic [1:0]       in_lane;
   logic [31:0]      ld_data;
   logic             done;

   load_ext u_load_ext (
      .funct3 (op_f3),
      .lane   (op_lane),
      .rdata  (dmem_rdata),
      .data   (ld_data)
   );

   assign stall_out = (state != IDLE);
   assign in_lane   = nat_lane(ex_in.funct3[1:0], ex_in.result[1:0]);
   // A load may see gnt and rvalid together; a store completes on gnt alone.
   assign done = ((state == REQ) && dmem_gnt && (op_store || dmem_rvalid)) ||
                 ((state == WAIT) && dmem_rvalid);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_be    <= '0;
         wb_out     <= '0;
         bus_err    <= 1'b0;
         op_store   <= 1'b0;
         op_rw      <= 1'b0;
         op_rd      <= '0;
         op_f3      <= '0;
         op_lane    <= '0;
      end else begin
         wb_out  <= '0;
         bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (ex_in.valid) begin
                  if (!ex_in.memRead && !ex_in.memWrite) begin
                     wb_out.valid    <= 1'b1;
                     wb_out.regWrite <= ex_in.regWrite;
                     wb_out.rd       <= ex_in.rd;
                     wb_out.wb_data  <= ex_in.result;
                  end
`ifdef MISALIGN_TRAP_EN
                  else if (misaligned(ex_in.funct3[1:0], ex_in.result[1:0])) begin
                     bus_err      <= 1'b1;
                     wb_out.valid <= 1'b1;
                     wb_out.rd    <= ex_in.rd;
                  end
`endif
                  else begin
                     state      <= REQ;
                     cnt        <= '0;
                     dmem_req   <= 1'b1;
                     dmem_we    <= !ex_in.memRead;
                     dmem_addr  <= {ex_in.result[31:2], 2'b00};
                     dmem_be    <= store_be(ex_in.funct3[1:0], in_lane);
                     dmem_wdata <= store_wdata(ex_in.funct3[1:0], ex_in.s_data);
                     op_store   <= !ex_in.memRead;
                     op_rw      <= ex_in.regWrite;
                     op_rd      <= ex_in.rd;
                     op_f3      <= ex_in.funct3;
                     op_lane    <= in_lane;
                  end
               end
            end
            REQ, WAIT: begin
               if ((state == REQ) && dmem_gnt)
                  dmem_req <= 1'b0;
               if (done) begin
                  state           <= IDLE;
                  wb_out.valid    <= 1'b1;
                  wb_out.regWrite <= op_rw & ~op_store;
                  wb_out.rd       <= op_rd;
                  wb_out.wb_data  <= op_store ? 32'h0 : ld_data;
               end else if (cnt == CNT_LAST) begin
                  state        <= IDLE;
                  dmem_req     <= 1'b0;
                  bus_err      <= 1'b1;
                  wb_out.valid <= 1'b1;
                  wb_out.rd    <= op_rd;
               end else begin
                  cnt <= cnt + 1'b1;
                  if ((state == REQ) && dmem_gnt)
                     state <= WAIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; expected write-backs are queued and checked by a monitor.
module tb_mem_stage;
   import struct_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   exmem_t      ex_in;
   logic        stall_out, dmem_req, dmem_we, dmem_gnt, dmem_rvalid, bus_err;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   memwb_t      wb_out;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT_CYC(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .ex_in       (ex_in),
      .stall_out   (stall_out),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_be     (dmem_be),
      .dmem_gnt    (dmem_gnt),
      .dmem_rvalid (dmem_rvalid),
      .dmem_rdata  (dmem_rdata),
      .wb_out      (wb_out),
      .bus_err     (bus_err)
   );

   typedef struct {
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        berr;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   stalls;
   int   n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic rw, input logic [4:0] rd, input logic [31:0] data, input logic berr);
      exp_t e;
      e.rw = rw; e.rd = rd; e.data = data; e.berr = berr;
      sb.push_back(e);
   endtask

   function automatic exmem_t mk(input logic rw, input logic mr, input logic mw, input logic [4:0] rd,
                                 input logic [2:0] f3, input logic [31:0] res, input logic [31:0] sd);
      exmem_t x;
      x.valid = 1'b1; x.regWrite = rw; x.memRead = mr; x.memWrite = mw;
      x.rd = rd; x.funct3 = f3; x.result = res; x.s_data = sd;
      return x;
   endfunction

   // Load answered with gnt and rvalid in the same cycle.
   task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp_addr, input logic [31:0] rdata, input logic [31:0] exp_data);
      ex_in = mk(1'b1, 1'b1, 1'b0, 5'd12, f3, addr, 32'h0);
      push(1'b1, 5'd12, exp_data, 1'b0);
      cyc(); ex_in = '0;
      chk({nm, "_addr"}, dmem_addr, exp_addr);
      chk({nm, "_req"}, 32'(dmem_req), 32'd1);
      dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = rdata;
      cyc(); dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      chk({nm, "_wb_valid"}, 32'(wb_out.valid), 32'd1);
   endtask

   task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      ex_in = mk(1'b1, 1'b0, 1'b1, 5'd13, f3, addr, sd);
      push(1'b0, 5'd13, 32'h0, 1'b0);
      cyc(); ex_in = '0;
      chk({nm, "_addr"}, dmem_addr, exp_addr);
      chk({nm, "_be"}, 32'(dmem_be), 32'(exp_be));
      chk({nm, "_wdata"}, dmem_wdata, exp_wdata);
      chk({nm, "_we"}, 32'(dmem_we), 32'd1);
      dmem_gnt = 1'b1;
      cyc(); dmem_gnt = 1'b0;
      chk({nm, "_wb_valid"}, 32'(wb_out.valid), 32'd1);
   endtask

   always @(negedge clk) begin
      if (!reset && wb_out.valid) begin
         if (sb.size() == 0) begin
            chk("wb_unexpected_valid", 32'(wb_out.valid), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("wb_regWrite", 32'(wb_out.regWrite), 32'(mon_e.rw));
            chk("wb_rd", 32'(wb_out.rd), 32'(mon_e.rd));
            if (mon_e.rw) chk("wb_data", wb_out.wb_data, mon_e.data);
            chk("wb_bus_err", 32'(bus_err), 32'(mon_e.berr));
         end
      end else if (!reset && bus_err) begin
         chk("bus_err_stray", 32'(bus_err), 32'd0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; ex_in = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      cyc(); cyc();
      chk("rst_stall", 32'(stall_out), 32'd0);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_we_be", 32'({dmem_we, dmem_be}), 32'd0);
      chk("rst_wb_valid", 32'(wb_out.valid), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      reset = 1'b0;
      cyc();

      // ALU op passes straight through
      ex_in = mk(1'b1, 1'b0, 1'b0, 5'd5, 3'b000, 32'h0000_0042, 32'h0);
      push(1'b1, 5'd5, 32'h0000_0042, 1'b0);
      cyc(); ex_in = '0;
      chk("add_wb_valid", 32'(wb_out.valid), 32'd1);
      chk("add_req", 32'(dmem_req), 32'd0);
      chk("add_stall", 32'(stall_out), 32'd0);
      cyc();
      chk("add_pulse", 32'(wb_out.valid), 32'd0);

      // LB at lane 3, gnt in cycle 1, rvalid in cycle 3; stray ex_in during stall
      ex_in = mk(1'b1, 1'b1, 1'b0, 5'd7, F3_LB, 32'h0000_0103, 32'h0);
      push(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0);
      stalls = 0;
      cyc(); ex_in = mk(1'b1, 1'b0, 1'b0, 5'd20, 3'b000, 32'h0000_0BAD, 32'h0);
      chk("lb_req", 32'(dmem_req), 32'd1);
      chk("lb_addr", dmem_addr, 32'h0000_0100);
      chk("lb_we", 32'(dmem_we), 32'd0);
      stalls += int'(stall_out);
      dmem_gnt = 1'b1;
      cyc(); dmem_gnt = 1'b0;
      chk("lb_req_drop", 32'(dmem_req), 32'd0);
      stalls += int'(stall_out);
      cyc(); dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FF00;
      stalls += int'(stall_out);
      cyc(); dmem_rvalid = 1'b0; ex_in = '0;
      chk("lb_wb_valid", 32'(wb_out.valid), 32'd1);
      chk("lb_stall_end", 32'(stall_out), 32'd0);
      chk("lb_stall_cycles", 32'(stalls), 32'd3);
      cyc();

      // SH at 0x202 with regWrite set on input: held until gnt, retires with regWrite=0
      ex_in = mk(1'b1, 1'b0, 1'b1, 5'd9, F3_SH, 32'h0000_0202, 32'h1234_ABCD);
      push(1'b0, 5'd9, 32'h0, 1'b0);
      cyc(); ex_in = '0;
      chk("sh_req", 32'(dmem_req), 32'd1);
      chk("sh_we", 32'(dmem_we), 32'd1);
      chk("sh_addr", dmem_addr, 32'h0000_0200);
      chk("sh_be", 32'(dmem_be), 32'b1100);
      chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
      cyc();
      chk("sh_hold_req", 32'(dmem_req), 32'd1);
      chk("sh_hold_be", 32'(dmem_be), 32'b1100);
      chk("sh_hold_wdata", dmem_wdata, 32'hABCD_ABCD);
      dmem_gnt = 1'b1;
      cyc(); dmem_gnt = 1'b0;
      chk("sh_wb_valid", 32'(wb_out.valid), 32'd1);
      chk("sh_req_drop", 32'(dmem_req), 32'd0);
      chk("sh_stall", 32'(stall_out), 32'd0);

      // LW granted but never answered: abort after 16 cycles in REQ+WAIT
      ex_in = mk(1'b1, 1'b1, 1'b0, 5'd3, F3_LW, 32'h0000_0400, 32'h0);
      push(1'b0, 5'd3, 32'h0, 1'b1);
      cyc(); ex_in = '0; dmem_gnt = 1'b1;
      cyc(); dmem_gnt = 1'b0;
      n = 2;
      while (!wb_out.valid && n < 40) begin
         cyc(); n++;
      end
      chk("to_cycle", 32'(n), 32'd17);
      chk("to_bus_err", 32'(bus_err), 32'd1);
      chk("to_stall", 32'(stall_out), 32'd0);
      chk("to_req", 32'(dmem_req), 32'd0);
      cyc();
      chk("to_bus_err_pulse", 32'(bus_err), 32'd0);

      // Reset mid-WAIT, then a late rvalid must be ignored
      ex_in = mk(1'b1, 1'b1, 1'b0, 5'd4, F3_LW, 32'h0000_0500, 32'h0);
      cyc(); ex_in = '0; dmem_gnt = 1'b1;
      cyc(); dmem_gnt = 1'b0;
      chk("rstw_pre_stall", 32'(stall_out), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rstw_async_stall", 32'(stall_out), 32'd0);
      chk("rstw_async_req", 32'(dmem_req), 32'd0);
      chk("rstw_async_wb", 32'(wb_out.valid), 32'd0);
      cyc(); reset = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
      cyc(); dmem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rstw_late_wb", 32'(wb_out.valid), 32'd0);
         cyc();
      end

      // Misaligned LW at 0x301
`ifdef MISALIGN_TRAP_EN
      ex_in = mk(1'b1, 1'b1, 1'b0, 5'd11, F3_LW, 32'h0000_0301, 32'h0);
      push(1'b0, 5'd11, 32'h0, 1'b1);
      cyc(); ex_in = '0;
      chk("mis_req", 32'(dmem_req), 32'd0);
      chk("mis_stall", 32'(stall_out), 32'd0);
      chk("mis_bus_err", 32'(bus_err), 32'd1);
      chk("mis_wb_valid", 32'(wb_out.valid), 32'd1);
      cyc();
`else
      do_load("mis_lw", F3_LW, 32'h0000_0301, 32'h0000_0300, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      chk("mis_bus_err", 32'(bus_err), 32'd0);
`endif

      // Remaining extension and store-lane vectors
      do_load("lhu", F3_LHU, 32'h0000_0602, 32'h0000_0600, 32'h8765_4321, 32'h0000_8765);
      do_load("lh",  F3_LH,  32'h0000_0000, 32'h0000_0000, 32'h1234_8001, 32'hFFFF_8001);
      do_load("lbu", F3_LBU, 32'h0000_0081, 32'h0000_0080, 32'h0000_F000, 32'h0000_00F0);
      do_store("sb", F3_SB, 32'h0000_0701, 32'h0000_0055, 32'h0000_0700, 4'b0010, 32'h5555_5555);
      do_store("sw", F3_SW, 32'h0000_0804, 32'hCAFE_F00D, 32'h0000_0804, 4'b1111, 32'hCAFE_F00D);
      cyc(); cyc();

      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
